mips_imem_loader: RTL and testbench

Boot-time program loader for the single-cycle MIPS core. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into instruction memory. It holds the core in reset until the image is fully written. It is the write side of the instruction-memory port that the core's fetch path reads.

---
 rtl/mips_imem_loader.sv | 187 ++++++++++++++++++
 tb/tb_mips_imem_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_imem_loader.sv
// Boot-time loader: byte stream -> big-endian instruction words -> imem writes; holds the core in reset until loaded.
// Optional checksum byte and CHECK state are enabled by defining LOADER_CHECKSUM_EN.
module mips_imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        FLUSH,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERR
    } state_e;

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [7:0]        hdr_hi_q, hdr_hi_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        accept;
    logic [15:0] count;

    assign accept = in_valid && in_ready;
    assign count  = {hdr_hi_q, in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HDR_HI;
            hdr_hi_q   <= '0;
            last_q     <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            hdr_hi_q   <= hdr_hi_d;
            last_q     <= last_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path infers a latch.
        state_d    = state_q;
        hdr_hi_d   = hdr_hi_q;
        last_d     = last_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        if (accept && (state_q == HDR_HI || state_q == HDR_LO || state_q == DATA))
            csum_d = csum_q ^ in_data;
`endif
        case (state_q)
            HDR_HI: begin
                if (accept) begin
                    hdr_hi_d = in_data;
                    state_d  = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    // Store N-1 so the last-word compare stays ADDR_W wide even for N = 2^ADDR_W.
                    last_d     = ADDR_W'(count - 16'd1);
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    if ({16'd0, count} > CAPACITY)
                        state_d = ERR;
                    else if (count == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], in_data};
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q;
                        wdata_d    = {shift_q, in_data};
                        word_cnt_d = word_cnt_q + ADDR_W'(1);
                        if (word_cnt_q == last_q)
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = FLUSH;
`endif
                    end
                end
            end
            FLUSH: state_d = DONE;
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept)
                    state_d = (in_data == csum_q) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (start) begin
                    state_d    = HDR_HI;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            default: state_d = HDR_HI;
        endcase
    end

    always_comb begin
        in_ready     = 1'b0;
        core_reset_n = 1'b0;
        load_done    = 1'b0;
        load_error   = 1'b0;
        case (state_q)
            HDR_HI, HDR_LO, DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHECK:                in_ready = 1'b1;
`endif
            DONE: begin
                core_reset_n = 1'b1;
                load_done    = 1'b1;
            end
            ERR:                  load_error = 1'b1;
            default:              in_ready = 1'b0;
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for mips_imem_loader at ADDR_W=2 (capacity 4 words); checksum cases follow LOADER_CHECKSUM_EN.
module tb_mips_imem_loader;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset_n;
    logic              load_done;
    logic              load_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    logic [31:0]       stim[$];

    mips_imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_we"}, imem_we, 0);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_rstn"}, core_reset_n, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_err"}, load_error, 0);
    endtask

    // Present one byte and hold it until the loader accepts it (bounded wait).
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit rdy;
        bit taken;
        @(negedge clk);
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        taken    = 1'b0;
        for (int i = 0; i < 20 && !taken; i++) begin
            rdy = in_ready;
            @(posedge clk);
            taken = rdy;
            if (!rdy) @(negedge clk);
        end
        if (!taken) check("accept_timeout", 0, 1);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_ready", in_ready, 1);
        check("restart_rstn", core_reset_n, 0);
        check("restart_done", load_done, 0);
        check("restart_err", load_error, 0);
    endtask

    // Load the words in stim and check the write sequence and release timing.
    task automatic load_words(input bit gap, input bit hold_valid);
        logic [15:0] n;
        logic [7:0]  cs;
        n = 16'(stim.size());
        wr_addr.delete();
        wr_data.delete();
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        cs = n[15:8] ^ n[7:0];
        foreach (stim[w]) begin
            for (int b = 3; b >= 0; b--) begin
                send_byte(stim[w][8*b +: 8], gap);
                cs = cs ^ stim[w][8*b +: 8];
            end
        end
        @(negedge clk);
        in_valid = hold_valid;
        in_data  = 8'hFF;
        check("last_we", imem_we, 1);
        check("last_rstn", core_reset_n, 0);
`ifdef LOADER_CHECKSUM_EN
        check("check_ready", in_ready, 1);
        send_byte(cs, 1'b0);
        @(negedge clk);
        in_valid = hold_valid;
`else
        check("flush_ready", in_ready, 0);
        @(negedge clk);
`endif
        check("release_done", load_done, 1);
        check("release_rstn", core_reset_n, 1);
        check("release_we", imem_we, 0);
        check("done_ready", in_ready, 0);
        if (hold_valid) begin
            repeat (3) @(negedge clk);
            check("hold_ready", in_ready, 0);
            check("hold_done", load_done, 1);
            in_valid = 1'b0;
        end
        check("n_writes", wr_addr.size(), stim.size());
        for (int i = 0; i < stim.size() && i < wr_addr.size(); i++) begin
            check($sformatf("waddr%0d", i), wr_addr[i], i);
            check($sformatf("wdata%0d", i), wr_data[i], stim[i]);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        // Partial image: header plus five payload bytes, then a one-cycle reset.
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h8C, 0); send_byte(8'h11, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
        send_byte(8'hAC, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("partial_wdata", imem_wdata, 32'h8C110004);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Two-word load back to back, then again with in_valid gaps and held valid after.
        stim = '{32'h8C110004, 32'hAC110008};
        load_words(1'b0, 1'b0);
        start_pulse();
        load_words(1'b1, 1'b1);

        // Full capacity: last word lands at address 3.
        start_pulse();
        stim = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        load_words(1'b0, 1'b0);

        // Count 5 exceeds 4-word capacity.
        start_pulse();
        wr_addr.delete();
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("ovf_err", load_error, 1);
        check("ovf_rstn", core_reset_n, 0);
        check("ovf_done", load_done, 0);
        check("ovf_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        check("ovf_writes", wr_addr.size(), 0);
        check("ovf_err_hold", load_error, 1);

        // Empty image.
        start_pulse();
        wr_addr.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        check("empty_check_ready", in_ready, 1);
        send_byte(8'h00, 0);
        @(negedge clk);
        in_valid = 1'b0;
`endif
        check("empty_done", load_done, 1);
        check("empty_rstn", core_reset_n, 1);
        check("empty_writes", wr_addr.size(), 0);

`ifdef LOADER_CHECKSUM_EN
        // XOR of 00 01 12 34 56 78 is 09.
        start_pulse();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'h09, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("csum_ok_done", load_done, 1);
        check("csum_ok_rstn", core_reset_n, 1);

        start_pulse();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
        send_byte(8'h08, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("csum_bad_err", load_error, 1);
        check("csum_bad_rstn", core_reset_n, 0);
        check("csum_bad_done", load_done, 0);
        start_pulse();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
